multihash_stream_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter sharing one multihash encode datapath among NUM_PORTS AXI-Stream hash producers.
//  A granted port owns the output until its tlast beat completes; no interleaving of beats from different packets.

---
 rtl/multihash_stream_arbiter_pkg.sv | 19 +
 rtl/multihash_stream_arbiter_rr_arbiter.sv | 34 +++
 rtl/multihash_stream_arbiter.sv | 151 +++++++++++++++
 tb/tb_multihash_stream_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multihash_stream_arbiter_pkg.sv
// Shared definitions for the multihash stream arbiter: FSM encodings, source-id
// field geometry and the round-robin pointer helper.
package multihash_stream_arbiter_pkg;

  localparam int SRC_ID_WIDTH       = 8;
  localparam int SRC_ID_LSB_DEFAULT = 24;
  localparam int CODEC_SLOT_LSB     = 32;
  localparam int CODEC_SLOT_MSB     = 47;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  function automatic int wrap_inc(input int cur, input int n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/multihash_stream_arbiter_rr_arbiter.sv
// Combinational rotate-priority pick: first requester at or after ptr_i, wrapping,
// reported both as a one-hot vector and as an index.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;

  // NOTE: combinational blocks use blocking assignments and give every output a
  // default before any branch, so no latch can be inferred.
  always_comb begin
    any_o    = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    cand     = '0;
    // Walk from farthest to nearest so the candidate closest to ptr_i wins last.
    for (int i = N - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr_i) + i) % N);
      if (req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
    if (any_o) onehot_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/multihash_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding one multihash encoder; the source
// port is stamped into TUSER. Define MHASH_ARB_STATS_EN for per-port packet counters.
module multihash_stream_arbiter
  import multihash_stream_arbiter_pkg::*;
#(
  parameter  int C_AXIS_DATA_WIDTH  = 512,
  parameter  int C_AXIS_TUSER_WIDTH = 128,
  parameter  int NUM_PORTS          = 4,
  parameter  int SRC_ID_LSB         = SRC_ID_LSB_DEFAULT,
  localparam int DW = C_AXIS_DATA_WIDTH,
  localparam int KW = C_AXIS_DATA_WIDTH / 8,
  localparam int UW = C_AXIS_TUSER_WIDTH,
  localparam int GW = $clog2(NUM_PORTS)
) (
  input  logic                    axis_aclk,
  input  logic                    reset,
  input  logic [NUM_PORTS*DW-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*KW-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS*UW-1:0] s_axis_tuser,
  input  logic [NUM_PORTS-1:0]    s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]    s_axis_tlast,
  output logic [NUM_PORTS-1:0]    s_axis_tready,
  output logic [DW-1:0]           m_axis_tdata,
  output logic [KW-1:0]           m_axis_tkeep,
  output logic [UW-1:0]           m_axis_tuser,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [GW-1:0]           grant_id
`ifdef MHASH_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0] pkt_count
`endif
);

  arb_state_e           state_q, state_d;
  logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]        grant_id_q, grant_id_d;
  logic [NUM_PORTS-1:0] grant_oh_q, grant_oh_d;

  logic [NUM_PORTS-1:0] pick_oh;
  logic [GW-1:0]        pick_idx;
  logic                 pick_any;

  logic [DW-1:0]        sel_tdata;
  logic [KW-1:0]        sel_tkeep;
  logic [UW-1:0]        sel_tuser;
  logic                 sel_tvalid;
  logic                 sel_tlast;
  logic                 pkt_done;

  rr_arbiter #(.N(NUM_PORTS)) u_rr_arbiter (
    .req_i    (s_axis_tvalid),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    sel_tdata  = '0;
    sel_tkeep  = '0;
    sel_tuser  = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_id_q == GW'(p)) begin
        sel_tdata  = s_axis_tdata[p*DW +: DW];
        sel_tkeep  = s_axis_tkeep[p*KW +: KW];
        sel_tuser  = s_axis_tuser[p*UW +: UW];
        sel_tvalid = s_axis_tvalid[p];
        sel_tlast  = s_axis_tlast[p];
      end
    end
  end

  // The codec slot and every other TUSER bit pass through; only the source-id byte changes.
  always_comb begin
    m_axis_tuser = sel_tuser;
    m_axis_tuser[SRC_ID_LSB +: SRC_ID_WIDTH] = SRC_ID_WIDTH'(grant_id_q);
  end

  assign m_axis_tdata = sel_tdata;
  assign m_axis_tkeep = sel_tkeep;
  assign m_axis_tlast = sel_tlast;
  assign grant_id     = grant_id_q;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    grant_oh_d    = grant_oh_q;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    pkt_done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d    = ST_BUSY;
          grant_id_d = pick_idx;
          grant_oh_d = pick_oh;
        end
      end
      ST_BUSY: begin
        m_axis_tvalid = sel_tvalid;
        s_axis_tready = grant_oh_q & {NUM_PORTS{m_axis_tready}};
        if (sel_tvalid && m_axis_tready && sel_tlast) begin
          pkt_done = 1'b1;
          state_d  = ST_IDLE;
          rr_ptr_d = GW'(wrap_inc(int'(grant_id_q), NUM_PORTS));
        end
      end
    endcase
  end

  // NOTE: reset is synchronous (sampled only on axis_aclk) and all state uses
  // non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge axis_aclk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      grant_oh_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      grant_oh_q <= grant_oh_d;
    end
  end

`ifdef MHASH_ARB_STATS_EN
  logic [31:0] pkt_count_q [NUM_PORTS];

  always_ff @(posedge axis_aclk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (reset) begin
        pkt_count_q[p] <= '0;
      end else if (pkt_done && grant_id_q == GW'(p)) begin
        pkt_count_q[p] <= pkt_count_q[p] + 32'd1;
      end
    end
  end

  always_comb begin
    pkt_count = '0;
    for (int p = 0; p < NUM_PORTS; p++) pkt_count[p*32 +: 32] = pkt_count_q[p];
  end
`endif

endmodule

// File: tb/tb_multihash_stream_arbiter.sv
// Directed bench for multihash_stream_arbiter: reset state, round-robin order,
// wrap-around, backpressure, mid-packet valid drop and (optionally) packet counters.
module tb_multihash_stream_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int UW = 64;
  localparam int GW = 2;

  logic               axis_aclk = 1'b0;
  logic               reset;
  logic [NP*DW-1:0]   s_axis_tdata;
  logic [NP*KW-1:0]   s_axis_tkeep;
  logic [NP*UW-1:0]   s_axis_tuser;
  logic [NP-1:0]      s_axis_tvalid;
  logic [NP-1:0]      s_axis_tlast;
  logic [NP-1:0]      s_axis_tready;
  logic [DW-1:0]      m_axis_tdata;
  logic [KW-1:0]      m_axis_tkeep;
  logic [UW-1:0]      m_axis_tuser;
  logic               m_axis_tvalid;
  logic               m_axis_tlast;
  logic               m_axis_tready;
  logic [GW-1:0]      grant_id;
`ifdef MHASH_ARB_STATS_EN
  logic [NP*32-1:0]   pkt_count;
`endif

  always #5 axis_aclk = ~axis_aclk;

  multihash_stream_arbiter #(
    .C_AXIS_DATA_WIDTH  (DW),
    .C_AXIS_TUSER_WIDTH (UW),
    .NUM_PORTS          (NP),
    .SRC_ID_LSB         (24)
  ) dut (
    .axis_aclk     (axis_aclk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .grant_id      (grant_id)
`ifdef MHASH_ARB_STATS_EN
    ,
    .pkt_count     (pkt_count)
`endif
  );

  // Per-port beat stores; a port offers its head beat until it is accepted.
  logic [DW-1:0] src_data [NP][32];
  logic [KW-1:0] src_keep [NP][32];
  logic          src_last [NP][32];
  int            src_cnt  [NP];
  int            src_head [NP];
  logic [NP-1:0] stall;
  logic          flush;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
    logic [GW-1:0] grant;
    int            cyc;
  } beat_t;

  beat_t out_q[$];
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic logic [DW-1:0] exp_data(input int p, input int pkt, input int b);
    return {8'(p), 8'(pkt), 16'(b)};
  endfunction

  function automatic logic [UW-1:0] in_user(input int p);
    return {16'h5A00 + 16'(p), 16'hC0DE, 8'hAA, 24'h123456};
  endfunction

  function automatic logic [UW-1:0] exp_user(input int p);
    return {16'h5A00 + 16'(p), 16'hC0DE, 8'(p), 24'h123456};
  endfunction

  always_comb begin
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = '0;
    for (int p = 0; p < NP; p++) begin
      s_axis_tuser[p*UW +: UW] = in_user(p);
      if (src_head[p] < src_cnt[p]) begin
        s_axis_tvalid[p]         = !stall[p];
        s_axis_tdata[p*DW +: DW] = src_data[p][src_head[p] % 32];
        s_axis_tkeep[p*KW +: KW] = src_keep[p][src_head[p] % 32];
        s_axis_tlast[p]          = src_last[p][src_head[p] % 32];
      end
    end
  end

  always @(posedge axis_aclk) begin
    cyc = cyc + 1;
    if (m_axis_tvalid && m_axis_tready)
      out_q.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, grant_id, cyc});
    for (int p = 0; p < NP; p++) begin
      if (flush) src_head[p] <= 0;
      else if (s_axis_tvalid[p] && s_axis_tready[p]) src_head[p] <= src_head[p] + 1;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_pkt(input int p, input int pkt, input int nb);
    for (int b = 0; b < nb; b++) begin
      src_data[p][src_cnt[p]] = exp_data(p, pkt, b);
      src_keep[p][src_cnt[p]] = KW'(b + 1);
      src_last[p][src_cnt[p]] = (b == nb - 1);
      src_cnt[p]++;
    end
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int t = 0;
    while (out_q.size() < n && t < budget) begin
      @(negedge axis_aclk);
      t++;
    end
    check({tag, " beat count"}, 128'(out_q.size()), 128'(n));
  endtask

  task automatic check_beat(input string tag, input int k, input int p, input int pkt,
                            input int b, input logic last);
    if (k >= out_q.size()) begin
      check($sformatf("%s beat%0d present", tag, k), 128'(out_q.size()), 128'(k + 1));
    end else begin
      check($sformatf("%s beat%0d", tag, k),
            128'({out_q[k].data, out_q[k].keep, out_q[k].user, out_q[k].last, out_q[k].grant}),
            128'({exp_data(p, pkt, b), KW'(b + 1), exp_user(p), last, GW'(p)}));
    end
  endtask

  task automatic check_gap(input string tag, input int k, input int gap);
    if (k >= out_q.size()) begin
      check($sformatf("%s gap%0d present", tag, k), 128'(out_q.size()), 128'(k + 1));
    end else begin
      check($sformatf("%s gap%0d", tag, k), 128'(out_q[k].cyc - out_q[k-1].cyc), 128'(gap));
    end
  endtask

  task automatic hard_reset();
    reset = 1'b1;
    flush = 1'b1;
    for (int p = 0; p < NP; p++) src_cnt[p] = 0;
  endtask

  initial begin
    stall         = '0;
    m_axis_tready = 1'b0;
    hard_reset();
    repeat (3) @(negedge axis_aclk);
    reset = 1'b0;
    flush = 1'b0;

    // Idle after reset: nothing offered, nothing accepted, grant at port 0.
    for (int i = 0; i < 10; i++) begin
      @(negedge axis_aclk);
      #1;
      check("reset idle", 128'({m_axis_tvalid, s_axis_tready, grant_id}), 128'(0));
    end

    // All four ports at once: served 0,1,2,3 with one bubble cycle between packets.
    @(negedge axis_aclk);
    out_q.delete();
    m_axis_tready = 1'b1;
    for (int p = 0; p < NP; p++) load_pkt(p, 0, 3);
    wait_beats(12, 200, "rr4");
    for (int k = 0; k < 12; k++) begin
      check_beat("rr4", k, k / 3, 0, k % 3, (k % 3) == 2);
      if (k > 0) check_gap("rr4", k, (k % 3 == 0) ? 2 : 1);
    end
    repeat (3) @(negedge axis_aclk);
    check("rr4 no extra beats", 128'(out_q.size()), 128'(12));

    // Port 2 alone, two packets: pointer wraps past 3 and returns to port 2.
    out_q.delete();
    load_pkt(2, 1, 3);
    load_pkt(2, 2, 3);
    wait_beats(6, 200, "p2x2");
    for (int k = 0; k < 6; k++) begin
      check_beat("p2x2", k, 2, 1 + k / 3, k % 3, (k % 3) == 2);
      if (k > 0) check_gap("p2x2", k, (k % 3 == 0) ? 2 : 1);
    end
    @(negedge axis_aclk);
    #1;
    check("p2x2 grant holds", 128'(grant_id), 128'(2));

    // Port 1 under toggling backpressure: tready mirrors, beats neither lost nor repeated.
    out_q.delete();
    load_pkt(1, 1, 4);
    for (int i = 0; i < 60 && out_q.size() < 4; i++) begin
      @(negedge axis_aclk);
      m_axis_tready = ~m_axis_tready;
      #1;
      check("tready mirror", 128'(s_axis_tready),
            128'({2'b00, m_axis_tready & m_axis_tvalid, 1'b0}));
    end
    check("toggle beat count", 128'(out_q.size()), 128'(4));
    for (int k = 0; k < 4; k++) check_beat("toggle", k, 1, 1, k, k == 3);
    @(negedge axis_aclk);
    m_axis_tready = 1'b1;
    repeat (2) @(negedge axis_aclk);
    check("toggle no extra beats", 128'(out_q.size()), 128'(4));

    // Port 0 pauses mid-packet while port 3 waits: no regrant until port 0 finishes.
    out_q.delete();
    load_pkt(0, 1, 4);
    wait_beats(2, 50, "stall pre");
    stall[0] = 1'b1;
    load_pkt(3, 1, 4);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall no valid", 128'(m_axis_tvalid), 128'(0));
      check("stall grant", 128'({grant_id, s_axis_tready[3]}), 128'({2'd0, 1'b0}));
      @(negedge axis_aclk);
    end
    stall[0] = 1'b0;
    wait_beats(8, 100, "stall");
    for (int k = 0; k < 4; k++) check_beat("stall p0", k, 0, 1, k, k == 3);
    for (int k = 4; k < 8; k++) check_beat("stall p3", k, 3, 1, k - 4, k == 7);
    check_gap("stall pause", 2, 5);

`ifdef MHASH_ARB_STATS_EN
    // Counters: 5 packets from port 1 and 2 from port 3, then reset mid-packet.
    @(negedge axis_aclk);
    hard_reset();
    @(negedge axis_aclk);
    reset = 1'b0;
    flush = 1'b0;
    out_q.delete();
    #1;
    check("stats cleared", 128'(pkt_count), 128'(0));
    for (int i = 0; i < 5; i++) load_pkt(1, i, 1);
    for (int i = 0; i < 2; i++) load_pkt(3, i, 1);
    wait_beats(7, 200, "stats");
    @(negedge axis_aclk);
    check("stats counts", 128'(pkt_count), {32'd2, 32'd0, 32'd5, 32'd0});
    load_pkt(2, 9, 3);
    wait_beats(8, 50, "stats midpkt");
    hard_reset();
    @(negedge axis_aclk);
    #1;
    check("stats reset midpkt", 128'({pkt_count, m_axis_tvalid}), 128'(0));
    reset = 1'b0;
    flush = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
